// File: rtl/ex_muldiv_unit_if.sv
// Handshake and data bundle between the ID/EX stage and the iterative mul/div unit.
// The master side drives operations and MTHI/MTLO writes; the unit reports HI/LO and status.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] i_BusA;
  logic [XLEN-1:0] i_BusB;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] i_wdata;
  logic [XLEN-1:0] o_hi;
  logic [XLEN-1:0] o_lo;
  logic            busy;
  logic            done;

  modport master (
    output start, op, i_BusA, i_BusB, hi_we, lo_we, i_wdata,
    input  o_hi, o_lo, busy, done
  );

  modport slave (
    input  start, op, i_BusA, i_BusB, hi_we, lo_we, i_wdata,
    output o_hi, o_lo, busy, done
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO: radix-2 shift-add multiply and
// restoring divide, one bit per cycle over 32 cycles, then a one-cycle sign fix-up.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  ex_muldiv_unit_if.slave   bus
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              sa_q, sb_q, dz_q;
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              done_q;

  logic              is_signed;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  always_comb begin
    is_signed = ~bus.op[0];
    a_mag     = (is_signed && bus.i_BusA[XLEN-1]) ? XLEN'(0) - bus.i_BusA : bus.i_BusA;
    b_mag     = (is_signed && bus.i_BusB[XLEN-1]) ? XLEN'(0) - bus.i_BusB : bus.i_BusB;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / growing quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_mag_q};
    div_diff  = div_shift[XLEN-1:0] - b_mag_q;
    if (op_q[1]) begin
      acc_d = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? (2*XLEN)'(0) - acc_q : acc_q;
    quot = (sa_q ^ sb_q) ? XLEN'(0) - acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? XLEN'(0) - acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!op_q[1]) begin
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end else if (dz_q) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem;
      fix_lo = quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_mag_q <= '0;
      acc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.hi_we) hi_q <= bus.i_wdata;
          if (bus.lo_we) lo_q <= bus.i_wdata;
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.i_BusA;
            b_mag_q <= b_mag;
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            sa_q    <= is_signed & bus.i_BusA[XLEN-1];
            sb_q    <= is_signed & bus.i_BusB[XLEN-1];
            dz_q    <= bus.op[1] & (bus.i_BusB == '0);
            cnt_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) state_q <= StFix;
        end
        StFix: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_hi = hi_q;
  assign bus.o_lo = lo_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected HI/LO are queued at launch and
// compared when done pulses, along with latency, busy width and corner cases.
module tb_ex_muldiv_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sbv; e = {p[63:32], p[31:0]}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; e = {p[63:32], p[31:0]}; end
      default: begin
        if (b == 32'b0) begin
          e = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          q = sa / sbv;
          r = sa % sbv;
          e = {r[31:0], q[31:0]};
        end else begin
          e = {a % b, a / b};
        end
      end
    endcase
    return e;
  endfunction

  // Launch at the next edge (edge k); returns #1 after edge k with operands scrambled.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input bit push);
    if (push) sb.push_back(e);
    bus.op     = op;
    bus.i_BusA = a;
    bus.i_BusB = b;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.i_BusA = $urandom;
    bus.i_BusB = $urandom;
  endtask

  task automatic wait_done(input string tag, input int n0);
    int   n;
    int   nb;
    exp_t e;
    n  = n0;
    nb = n0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (bus.busy === 1'b1) nb++;
      tick();
      n++;
    end
    e = sb.pop_front();
    if (bus.done === 1'b1) begin
      check({tag, " latency"}, n, 33);
      check({tag, " busy_cycles"}, nb, 33);
      check({tag, " busy_at_done"}, {31'b0, bus.busy}, 0);
      check({tag, " hi"}, bus.o_hi, e.hi);
      check({tag, " lo"}, bus.o_lo, e.lo);
    end else begin
      total++;
      bad++;
      $error("FAIL %s timeout: observed=no done expected=done within 33 cycles", tag);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    launch(op, a, b, {ehi, elo}, 1'b1);
    check({tag, " busy_after_start"}, {31'b0, bus.busy}, 1);
    wait_done(tag, 0);
  endtask

  initial begin
    int   seen_done;
    exp_t e;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.i_BusA  = '0;
    bus.i_BusB  = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.i_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset hi", bus.o_hi, 0);
    check("reset lo", bus.o_lo, 0);
    check("reset busy", {31'b0, bus.busy}, 0);
    check("reset done", {31'b0, bus.done}, 0);

    bus.hi_we = 1'b1; bus.i_wdata = 32'hCAFE_BABE; tick(); bus.hi_we = 1'b0;
    check("mthi", bus.o_hi, 32'hCAFE_BABE);
    bus.lo_we = 1'b1; bus.i_wdata = 32'h1234_5678; tick(); bus.lo_we = 1'b0;
    check("mtlo", bus.o_lo, 32'h1234_5678);
    check("mtlo keeps hi", bus.o_hi, 32'hCAFE_BABE);

    run("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mult min^2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run("divu by0", 2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
    run("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

    for (int i = 0; i < 4; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'(i);
      a  = $urandom;
      b  = $urandom;
      e  = model(op, a, b);
      run("random", op, a, b, e.hi, e.lo);
    end

    // Start and lo_we while busy must both be dropped.
    launch(2'b01, 32'd3, 32'd5, {32'h0, 32'd15}, 1'b1);
    tick(); tick(); tick();
    bus.start = 1'b1; bus.op = 2'b10; bus.lo_we = 1'b1; bus.i_wdata = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check("lo_we while busy", bus.o_lo, e.lo);
    wait_done("ignored start", 4);
    tick();
    check("start not queued", {31'b0, bus.busy}, 0);

    // Reset mid-CALC discards the operation.
    launch(2'b01, 32'd9, 32'd9, '0, 1'b0);
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midreset busy", {31'b0, bus.busy}, 0);
    check("midreset hi", bus.o_hi, 0);
    check("midreset lo", bus.o_lo, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen_done++;
      tick();
    end
    check("midreset no done", seen_done, 0);

    // Back-to-back: second start in the done cycle.
    launch(2'b00, 32'hFFFF_FFF0, 32'd16, {32'hFFFF_FFFF, 32'hFFFF_FF00}, 1'b1);
    wait_done("b2b first", 0);
    launch(2'b11, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b1);
    check("b2b busy", {31'b0, bus.busy}, 1);
    wait_done("b2b second", 0);

    // Write and start together: result overwrites the written LO.
    bus.lo_we = 1'b1; bus.i_wdata = 32'h5555_5555;
    launch(2'b01, 32'd6, 32'd7, {32'h0, 32'd42}, 1'b1);
    bus.lo_we = 1'b0;
    check("write+start lo", bus.o_lo, 32'h5555_5555);
    wait_done("write+start", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
